// File: rtl/priv_trap_sequencer_if.sv
// Bundle between the hazard unit / interrupt sources / CSR file and the trap sequencer.
// master drives the request side, slave is the sequencer itself.
interface priv_trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            fault_insn, mal_insn, illegal_insn;
  logic            fault_l, mal_l, fault_s, mal_s;
  logic            breakpoint, env;
  logic            fault_insn_page, fault_load_page, fault_store_page;
  logic            mret, wfi, ex_mem_stall, pipe_clear;
  logic [XLEN-1:0] epc, badaddr;
  logic            timer_int, soft_int, ext_int;
  logic            mie_timer, mie_soft, mie_ext, mstatus_mie;
  logic [XLEN-1:0] mtvec, mepc_r;
  logic            insert_pc;
  logic [XLEN-1:0] priv_pc;
  logic            intr, trap_commit, mret_commit;
  logic [XLEN-1:0] mcause_wdata, mepc_wdata, mtval_wdata;
  logic            wfi_sleep, redirect_err;

  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
           mret, wfi, ex_mem_stall, pipe_clear, epc, badaddr,
           timer_int, soft_int, ext_int, mie_timer, mie_soft, mie_ext, mstatus_mie,
           mtvec, mepc_r,
    input  insert_pc, priv_pc, intr, trap_commit, mret_commit,
           mcause_wdata, mepc_wdata, mtval_wdata, wfi_sleep, redirect_err
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env, fault_insn_page, fault_load_page, fault_store_page,
           mret, wfi, ex_mem_stall, pipe_clear, epc, badaddr,
           timer_int, soft_int, ext_int, mie_timer, mie_soft, mie_ext, mstatus_mie,
           mtvec, mepc_r,
    output insert_pc, priv_pc, intr, trap_commit, mret_commit,
           mcause_wdata, mepc_wdata, mtval_wdata, wfi_sleep, redirect_err
  );
endinterface

// File: rtl/priv_trap_sequencer.sv
// Trap entry / mret / wfi sequencer: picks the winning event, commits CSR values, redirects the pipe.
// Optional VECTORED_TRAP_EN: mtvec mode 2'b01 sends interrupts to base + 4*cause.
module priv_trap_sequencer #(
  parameter int XLEN           = 32,
  parameter int RESUME_TIMEOUT = 15
) (
  input logic                  CLK,
  input logic                  nRST,
  priv_trap_sequencer_if.slave bus
);
  localparam int CW = $clog2(RESUME_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(RESUME_TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(RESUME_TIMEOUT);

  // Bit 11 is the highest priority exception; the table gives each bit's mcause code.
  localparam logic [11:0][3:0] EXC_CODE = {4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd11,
                                           4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5};

  typedef enum logic [1:0] {IDLE, REDIRECT, SLEEP} state_t;

  state_t          state_reg;
  logic            insert_pc_reg, intr_reg, trap_commit_reg, mret_commit_reg;
  logic            wfi_sleep_reg, redirect_err_reg;
  logic [XLEN-1:0] priv_pc_reg, mcause_reg, mepc_reg, mtval_reg;
  logic [CW-1:0]   tmo_cnt_reg;

  logic [11:0]     exc_vec;
  logic            exc_any, exc_is_env;
  logic [3:0]      exc_code;
  logic [2:0]      pend_en;
  logic            irq_any, irq_take;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] trap_base, irq_target, exc_cause, irq_cause;

  assign exc_vec = {bus.breakpoint, bus.fault_insn_page, bus.fault_insn, bus.illegal_insn,
                    bus.mal_insn, bus.env, bus.mal_s, bus.mal_l, bus.fault_store_page,
                    bus.fault_load_page, bus.fault_s, bus.fault_l};
  assign exc_any = |exc_vec;

  // Scan low to high so the highest set bit overwrites the rest.
  always_comb begin
    exc_code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (exc_vec[i]) exc_code = EXC_CODE[i];
    end
  end

  assign exc_is_env = (exc_code == 4'd11);
  assign exc_cause  = {{(XLEN-4){1'b0}}, exc_code};

  assign pend_en  = {bus.ext_int & bus.mie_ext, bus.soft_int & bus.mie_soft,
                     bus.timer_int & bus.mie_timer};
  assign irq_any  = |pend_en;
  assign irq_take = irq_any & bus.mstatus_mie;
  assign irq_code = pend_en[2] ? 4'd11 : (pend_en[1] ? 4'd3 : 4'd7);
  assign irq_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};

  assign trap_base = {bus.mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
  assign irq_target = (bus.mtvec[1:0] == 2'b01)
                    ? trap_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                    : trap_base;
`else
  logic unused_mode;
  assign unused_mode = ^bus.mtvec[1:0];
  assign irq_target  = trap_base;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg        <= IDLE;
      insert_pc_reg    <= 1'b0;
      intr_reg         <= 1'b0;
      trap_commit_reg  <= 1'b0;
      mret_commit_reg  <= 1'b0;
      wfi_sleep_reg    <= 1'b0;
      redirect_err_reg <= 1'b0;
      priv_pc_reg      <= '0;
      mcause_reg       <= '0;
      mepc_reg         <= '0;
      mtval_reg        <= '0;
      tmo_cnt_reg      <= '0;
    end else begin
      trap_commit_reg <= 1'b0;
      mret_commit_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tmo_cnt_reg <= '0;
          if (!bus.ex_mem_stall) begin
            if (exc_any) begin
              mcause_reg      <= exc_cause;
              mepc_reg        <= bus.epc;
              mtval_reg       <= exc_is_env ? '0 : bus.badaddr;
              intr_reg        <= 1'b0;
              priv_pc_reg     <= trap_base;
              trap_commit_reg <= 1'b1;
              insert_pc_reg   <= 1'b1;
              state_reg       <= REDIRECT;
            end else if (irq_take) begin
              mcause_reg      <= irq_cause;
              mepc_reg        <= bus.epc;
              mtval_reg       <= '0;
              intr_reg        <= 1'b1;
              priv_pc_reg     <= irq_target;
              trap_commit_reg <= 1'b1;
              insert_pc_reg   <= 1'b1;
              state_reg       <= REDIRECT;
            end else if (bus.mret) begin
              intr_reg        <= 1'b0;
              priv_pc_reg     <= bus.mepc_r;
              mret_commit_reg <= 1'b1;
              insert_pc_reg   <= 1'b1;
              state_reg       <= REDIRECT;
            end else if (bus.wfi) begin
              wfi_sleep_reg   <= 1'b1;
              state_reg       <= SLEEP;
            end
          end
        end
        REDIRECT: begin
          // Timeout only flags the problem; the redirect keeps waiting for the drain.
          if (tmo_cnt_reg != TMO_MAX) tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
          if (tmo_cnt_reg == TMO_LAST) redirect_err_reg <= 1'b1;
          if (bus.pipe_clear) begin
            insert_pc_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        SLEEP: begin
          // Wake ignores mstatus_mie; IDLE then decides whether the interrupt is taken.
          if (irq_any) begin
            wfi_sleep_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.insert_pc    = insert_pc_reg;
  assign bus.priv_pc      = priv_pc_reg;
  assign bus.intr         = intr_reg;
  assign bus.trap_commit  = trap_commit_reg;
  assign bus.mret_commit  = mret_commit_reg;
  assign bus.mcause_wdata = mcause_reg;
  assign bus.mepc_wdata   = mepc_reg;
  assign bus.mtval_wdata  = mtval_reg;
  assign bus.wfi_sleep    = wfi_sleep_reg;
  assign bus.redirect_err = redirect_err_reg;
endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Self-checking bench for priv_trap_sequencer: directed scenarios plus randomized
// transactions predicted by a transaction-level reference model.
module tb_priv_trap_sequencer;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  priv_trap_sequencer_if #(.XLEN(32)) bus ();

  priv_trap_sequencer #(.XLEN(32), .RESUME_TIMEOUT(15)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Priority order, highest first: breakpoint, insn page, insn fault, illegal, mal insn,
  // env, mal store, mal load, store page, load page, store fault, load fault.
  localparam int EXC_CODES [12] = '{3, 12, 1, 2, 0, 11, 6, 4, 15, 13, 7, 5};

  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 trap, 2 mret, 3 sleep
    logic [31:0] cause;
    logic [31:0] mtval;
    logic [31:0] pc;
    logic        intr;
  } pred_t;

  function automatic pred_t predict(input logic [11:0] exc, input logic [2:0] irq,
                                    input logic gie, input logic do_mret, input logic do_wfi,
                                    input logic [31:0] bad, input logic [31:0] tvec,
                                    input logic [31:0] mepc_v);
    pred_t p;
    int    code;
    p       = '0;
    p.pc    = {tvec[31:2], 2'b00};
    for (int i = 0; i < 12; i++) begin
      if (exc[i]) begin
        p.kind  = 2'd1;
        p.cause = 32'(EXC_CODES[i]);
        p.mtval = (i == 5) ? 32'h0 : bad;
        return p;
      end
    end
    if (gie && (irq != 3'b000)) begin
      code    = irq[2] ? 11 : (irq[1] ? 3 : 7);
      p.kind  = 2'd1;
      p.cause = 32'h8000_0000 | 32'(code);
      p.intr  = 1'b1;
`ifdef VECTORED_TRAP_EN
      if (tvec[1:0] == 2'b01) p.pc = p.pc + 32'(4 * code);
`endif
      return p;
    end
    if (do_mret) begin
      p.kind = 2'd2;
      p.pc   = mepc_v;
    end else if (do_wfi) begin
      p.kind = 2'd3;
    end
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.fault_insn = 0; bus.mal_insn = 0; bus.illegal_insn = 0; bus.fault_l = 0;
    bus.mal_l = 0; bus.fault_s = 0; bus.mal_s = 0; bus.breakpoint = 0; bus.env = 0;
    bus.fault_insn_page = 0; bus.fault_load_page = 0; bus.fault_store_page = 0;
    bus.mret = 0; bus.wfi = 0; bus.timer_int = 0; bus.soft_int = 0; bus.ext_int = 0;
  endtask

  task automatic init_inputs();
    clear_events();
    bus.ex_mem_stall = 0; bus.pipe_clear = 0; bus.epc = '0; bus.badaddr = '0;
    bus.mie_timer = 0; bus.mie_soft = 0; bus.mie_ext = 0; bus.mstatus_mie = 0;
    bus.mtvec = '0; bus.mepc_r = '0;
  endtask

  task automatic test_reset();
    init_inputs();
    rst_n = 1'b0;
    step(); step();
    checks++; if ({bus.insert_pc, bus.intr, bus.trap_commit, bus.mret_commit, bus.wfi_sleep, bus.redirect_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=000000", {bus.insert_pc, bus.intr, bus.trap_commit, bus.mret_commit, bus.wfi_sleep, bus.redirect_err}); end
    checks++; if ({bus.priv_pc, bus.mcause_wdata, bus.mepc_wdata, bus.mtval_wdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data got=%h %h %h %h exp=0", bus.priv_pc, bus.mcause_wdata, bus.mepc_wdata, bus.mtval_wdata); end
    #2 rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  task automatic test_illegal();
    bus.illegal_insn = 1; bus.epc = 32'h200; bus.badaddr = 32'hDEAD; bus.mtvec = 32'h1000;
    step();
    clear_events();
    $display("txn illegal: commit=%b mcause=%h mepc=%h mtval=%h pc=%h", bus.trap_commit, bus.mcause_wdata, bus.mepc_wdata, bus.mtval_wdata, bus.priv_pc);
    checks++; if (bus.trap_commit !== 1'b1) begin errors++; $display("FAIL ill_commit got=%b exp=1", bus.trap_commit); end
    checks++; if (bus.mcause_wdata !== 32'd2) begin errors++; $display("FAIL ill_mcause got=%h exp=2", bus.mcause_wdata); end
    checks++; if (bus.mepc_wdata !== 32'h200) begin errors++; $display("FAIL ill_mepc got=%h exp=200", bus.mepc_wdata); end
    checks++; if (bus.mtval_wdata !== 32'hDEAD) begin errors++; $display("FAIL ill_mtval got=%h exp=dead", bus.mtval_wdata); end
    checks++; if (bus.insert_pc !== 1'b1 || bus.priv_pc !== 32'h1000) begin
      errors++; $display("FAIL ill_redirect got=%b/%h exp=1/1000", bus.insert_pc, bus.priv_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.trap_commit !== 1'b0 || bus.insert_pc !== 1'b1) begin
        errors++; $display("FAIL ill_hold%0d got=commit %b insert %b exp=0 1", i, bus.trap_commit, bus.insert_pc); end
    end
    bus.pipe_clear = 1;
    step();
    bus.pipe_clear = 0;
    checks++; if (bus.insert_pc !== 1'b0) begin errors++; $display("FAIL ill_release got=%b exp=0", bus.insert_pc); end
    checks++; if (bus.redirect_err !== 1'b0) begin errors++; $display("FAIL ill_no_err got=%b exp=0", bus.redirect_err); end
  endtask

  task automatic test_exc_beats_intr();
    bus.breakpoint = 1; bus.fault_l = 1; bus.ext_int = 1; bus.mie_ext = 1; bus.mstatus_mie = 1;
    bus.epc = 32'h400; bus.badaddr = 32'h44;
    step();
    clear_events();
    $display("txn exc_vs_intr: mcause=%h intr=%b", bus.mcause_wdata, bus.intr);
    checks++; if (bus.mcause_wdata !== 32'd3) begin errors++; $display("FAIL prio_mcause got=%h exp=3", bus.mcause_wdata); end
    checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL prio_intr got=%b exp=0", bus.intr); end
    bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
    bus.mie_ext = 0; bus.mstatus_mie = 0;
  endtask

  task automatic test_stall();
    bus.ext_int = 1; bus.timer_int = 1; bus.mie_ext = 1; bus.mie_timer = 1; bus.mstatus_mie = 1;
    bus.ex_mem_stall = 1; bus.epc = 32'h880;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.trap_commit !== 1'b0 || bus.insert_pc !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got=commit %b insert %b exp=0 0", i, bus.trap_commit, bus.insert_pc); end
    end
    bus.ex_mem_stall = 0;
    step();
    clear_events();
    $display("txn stall_release: commit=%b mcause=%h intr=%b", bus.trap_commit, bus.mcause_wdata, bus.intr);
    checks++; if (bus.trap_commit !== 1'b1 || bus.mcause_wdata !== 32'h8000000B) begin
      errors++; $display("FAIL stall_mcause got=%b/%h exp=1/8000000b", bus.trap_commit, bus.mcause_wdata); end
    checks++; if (bus.intr !== 1'b1 || bus.mtval_wdata !== 32'h0 || bus.mepc_wdata !== 32'h880) begin
      errors++; $display("FAIL stall_fields got=%b/%h/%h exp=1/0/880", bus.intr, bus.mtval_wdata, bus.mepc_wdata); end
    bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
    bus.mie_ext = 0; bus.mie_timer = 0; bus.mstatus_mie = 0;
  endtask

  task automatic test_mret();
    bus.mret = 1; bus.mepc_r = 32'h340;
    step();
    clear_events();
    $display("txn mret: mret_commit=%b trap_commit=%b pc=%h", bus.mret_commit, bus.trap_commit, bus.priv_pc);
    checks++; if (bus.mret_commit !== 1'b1 || bus.trap_commit !== 1'b0) begin
      errors++; $display("FAIL mret_strobe got=%b/%b exp=1/0", bus.mret_commit, bus.trap_commit); end
    checks++; if (bus.priv_pc !== 32'h340 || bus.insert_pc !== 1'b1) begin
      errors++; $display("FAIL mret_pc got=%h/%b exp=340/1", bus.priv_pc, bus.insert_pc); end
    step();
    checks++; if (bus.mret_commit !== 1'b0) begin errors++; $display("FAIL mret_pulse got=%b exp=0", bus.mret_commit); end
    bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
  endtask

  task automatic test_wfi();
    bus.mstatus_mie = 0; bus.wfi = 1;
    step();
    bus.wfi = 0;
    checks++; if (bus.wfi_sleep !== 1'b1) begin errors++; $display("FAIL wfi_enter got=%b exp=1", bus.wfi_sleep); end
    bus.illegal_insn = 1;
    step();
    checks++; if (bus.wfi_sleep !== 1'b1 || bus.trap_commit !== 1'b0) begin
      errors++; $display("FAIL wfi_ignore_exc got=%b/%b exp=1/0", bus.wfi_sleep, bus.trap_commit); end
    bus.illegal_insn = 0; bus.timer_int = 1; bus.mie_timer = 1;
    step();
    bus.timer_int = 0;
    $display("txn wfi_wake: wfi_sleep=%b", bus.wfi_sleep);
    checks++; if (bus.wfi_sleep !== 1'b0) begin errors++; $display("FAIL wfi_wake got=%b exp=0", bus.wfi_sleep); end
    step();
    checks++; if (bus.trap_commit !== 1'b0 || bus.insert_pc !== 1'b0) begin
      errors++; $display("FAIL wfi_no_trap got=%b/%b exp=0/0", bus.trap_commit, bus.insert_pc); end
    bus.mie_timer = 0;
  endtask

  task automatic test_back_to_back();
    bus.mstatus_mie = 1; bus.wfi = 1; bus.mtvec = 32'h2000;
    step();
    bus.wfi = 0; bus.timer_int = 1; bus.mie_timer = 1; bus.epc = 32'h1234;
    step();
    checks++; if (bus.wfi_sleep !== 1'b0 || bus.trap_commit !== 1'b0) begin
      errors++; $display("FAIL b2b_wake got=%b/%b exp=0/0", bus.wfi_sleep, bus.trap_commit); end
    step();
    clear_events();
    $display("txn wake_then_trap: commit=%b mcause=%h mepc=%h", bus.trap_commit, bus.mcause_wdata, bus.mepc_wdata);
    checks++; if (bus.trap_commit !== 1'b1 || bus.mcause_wdata !== 32'h80000007 || bus.mepc_wdata !== 32'h1234) begin
      errors++; $display("FAIL b2b_trap got=%b/%h/%h exp=1/80000007/1234", bus.trap_commit, bus.mcause_wdata, bus.mepc_wdata); end
    bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
    bus.mie_timer = 0; bus.mstatus_mie = 0;
  endtask

`ifdef VECTORED_TRAP_EN
  task automatic test_vectored();
    bus.mtvec = 32'h1001; bus.soft_int = 1; bus.mie_soft = 1; bus.mstatus_mie = 1;
    step();
    clear_events();
    $display("txn vectored: pc=%h", bus.priv_pc);
    checks++; if (bus.priv_pc !== 32'h100C) begin errors++; $display("FAIL vec_pc got=%h exp=100c", bus.priv_pc); end
    bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
    bus.mie_soft = 0; bus.mstatus_mie = 0;
  endtask
`endif

  task automatic test_random(input int n);
    logic [11:0] exc;
    logic [2:0]  pend, en;
    logic        gie, m, w;
    logic [31:0] e, b, t, mr;
    pred_t       p;
    for (int k = 0; k < n; k++) begin
      exc = '0;
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < 12; i++) exc[i] = ($urandom_range(0, 5) == 0);
      pend = 3'($urandom); en = 3'($urandom); gie = 1'($urandom);
      m = ($urandom_range(0, 2) == 0); w = ($urandom_range(0, 2) == 0);
      e = $urandom; b = $urandom; t = $urandom; mr = $urandom;
      bus.breakpoint = exc[0]; bus.fault_insn_page = exc[1]; bus.fault_insn = exc[2];
      bus.illegal_insn = exc[3]; bus.mal_insn = exc[4]; bus.env = exc[5]; bus.mal_s = exc[6];
      bus.mal_l = exc[7]; bus.fault_store_page = exc[8]; bus.fault_load_page = exc[9];
      bus.fault_s = exc[10]; bus.fault_l = exc[11];
      bus.timer_int = pend[0]; bus.soft_int = pend[1]; bus.ext_int = pend[2];
      bus.mie_timer = en[0]; bus.mie_soft = en[1]; bus.mie_ext = en[2]; bus.mstatus_mie = gie;
      bus.mret = m; bus.wfi = w; bus.epc = e; bus.badaddr = b; bus.mtvec = t; bus.mepc_r = mr;
      p = predict(exc, pend & en, gie, m, w, b, t, mr);
      step();
      clear_events();
      $display("txn rnd%0d exc=%03h irq=%b gie=%b mret=%b wfi=%b kind=%0d", k, exc, pend & en, gie, m, w, p.kind);
      checks++; if ({bus.trap_commit, bus.mret_commit, bus.insert_pc, bus.wfi_sleep} !== {p.kind == 2'd1, p.kind == 2'd2, p.kind == 2'd1 || p.kind == 2'd2, p.kind == 2'd3}) begin
        errors++; $display("FAIL rnd%0d_flags got=%b exp_kind=%0d", k, {bus.trap_commit, bus.mret_commit, bus.insert_pc, bus.wfi_sleep}, p.kind); end
      if (p.kind == 2'd1) begin
        checks++; if ({bus.mcause_wdata, bus.mepc_wdata, bus.mtval_wdata, bus.priv_pc, bus.intr} !== {p.cause, e, p.mtval, p.pc, p.intr}) begin
          errors++; $display("FAIL rnd%0d_trap got=%h/%h/%h/%h/%b exp=%h/%h/%h/%h/%b", k, bus.mcause_wdata, bus.mepc_wdata, bus.mtval_wdata, bus.priv_pc, bus.intr, p.cause, e, p.mtval, p.pc, p.intr); end
      end else if (p.kind == 2'd2) begin
        checks++; if (bus.priv_pc !== p.pc || bus.intr !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_mret got=%h/%b exp=%h/0", k, bus.priv_pc, bus.intr, p.pc); end
      end
      if (p.kind == 2'd1 || p.kind == 2'd2) begin
        step();
        checks++; if ({bus.trap_commit, bus.mret_commit, bus.insert_pc} !== 3'b001) begin
          errors++; $display("FAIL rnd%0d_hold got=%b exp=001", k, {bus.trap_commit, bus.mret_commit, bus.insert_pc}); end
        bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
        checks++; if (bus.insert_pc !== 1'b0) begin errors++; $display("FAIL rnd%0d_release got=%b exp=0", k, bus.insert_pc); end
      end else if (p.kind == 2'd3) begin
        bus.mstatus_mie = 0; bus.timer_int = 1; bus.mie_timer = 1;
        step();
        bus.timer_int = 0;
        checks++; if (bus.wfi_sleep !== 1'b0) begin errors++; $display("FAIL rnd%0d_wake got=%b exp=0", k, bus.wfi_sleep); end
        step();
      end
    end
    bus.mstatus_mie = 0; bus.mie_timer = 0; bus.mie_soft = 0; bus.mie_ext = 0;
  endtask

  task automatic test_timeout();
    bus.mtvec = 32'h1000; bus.illegal_insn = 1;
    step();
    clear_events();
    for (int i = 0; i < 10; i++) step();
    checks++; if (bus.redirect_err !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", bus.redirect_err); end
    for (int i = 0; i < 6; i++) step();
    $display("txn timeout: redirect_err=%b insert_pc=%b", bus.redirect_err, bus.insert_pc);
    checks++; if (bus.redirect_err !== 1'b1 || bus.insert_pc !== 1'b1) begin
      errors++; $display("FAIL tmo_flag got=%b/%b exp=1/1", bus.redirect_err, bus.insert_pc); end
    bus.pipe_clear = 1; step(); bus.pipe_clear = 0;
    checks++; if (bus.redirect_err !== 1'b1 || bus.insert_pc !== 1'b0) begin
      errors++; $display("FAIL tmo_sticky got=%b/%b exp=1/0", bus.redirect_err, bus.insert_pc); end
    // A reset in the middle of a redirect must abort it and clear the sticky flag.
    bus.illegal_insn = 1;
    step();
    clear_events();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.insert_pc, bus.trap_commit, bus.redirect_err} !== 3'b000) begin
      errors++; $display("FAIL reset_abort got=%b exp=000", {bus.insert_pc, bus.trap_commit, bus.redirect_err}); end
    #3 rst_n = 1'b1;
    step();
    checks++; if ({bus.insert_pc, bus.trap_commit, bus.mret_commit} !== 3'b000) begin
      errors++; $display("FAIL post_abort got=%b exp=000", {bus.insert_pc, bus.trap_commit, bus.mret_commit}); end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_exc_beats_intr();
    test_stall();
    test_mret();
    test_wfi();
    test_back_to_back();
`ifdef VECTORED_TRAP_EN
    test_vectored();
`endif
    test_random(60);
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/priv_trap_sequencer.md
Name: priv_trap_sequencer

Overview:
- Trap-entry/return sequencer inside the privilege block.
- Sits directly downstream of the hazard unit. Consumes its exception flags, epc, badaddr, mret, wfi and ex_mem_stall.
- Consumes interrupt-pending lines from the CLINT/PLIC.
- Produces priv_pc, insert_pc and intr back to the hazard unit, plus one-cycle commit strobes to the CSR file (mcause/mepc/mtval writes, mret).

Parameters:
- XLEN, 32, datapath width.
- RESUME_TIMEOUT, 15, cycles to hold insert_pc waiting for pipe_clear before flagging a redirect_err.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env  in  1 each  exception flags from hazard unit.
- fault_insn_page, fault_load_page, fault_store_page  in  1 each  TLB page faults.
- mret, wfi  in  1 each  committed mret / wfi instruction.
- ex_mem_stall  in  1  EX/MEM stage stalled; no event is accepted while high.
- pipe_clear  in  1  pipeline drained after redirect.
- epc  in  XLEN  PC of the faulting/committing instruction.
- badaddr  in  XLEN  faulting address / instruction bits.
- timer_int, soft_int, ext_int  in  1 each  pending interrupts (mip).
- mie_timer, mie_soft, mie_ext  in  1 each  individual enables (mie).
- mstatus_mie  in  1  global M interrupt enable.
- mtvec  in  XLEN  trap base; bits[1:0] are the mode.
- mepc_r  in  XLEN  current mepc.
- insert_pc  out  1  redirect request to hazard unit.
- priv_pc  out  XLEN  redirect target.
- intr  out  1  current trap is an interrupt.
- trap_commit  out  1  one-cycle strobe: write mcause/mepc/mtval.
- mret_commit  out  1  one-cycle strobe: pop mstatus.
- mcause_wdata, mepc_wdata, mtval_wdata  out  XLEN each  values for the CSR file.
- wfi_sleep  out  1  core sleeping.
- redirect_err  out  1  sticky flag: pipe_clear timeout.

Behaviour:
- Reset: state IDLE; all outputs 0; captured registers 0; timeout counter 0. Reset mid-sequence aborts it with no strobes.
- States: IDLE, REDIRECT, SLEEP.

IDLE (event accepted only when ex_mem_stall==0):
- Exception priority, highest first (mcause code in parentheses):
  - breakpoint(3)
  - fault_insn_page(12)
  - fault_insn(1)
  - illegal_insn(2)
  - mal_insn(0)
  - env(11)
  - mal_s(6)
  - mal_l(4)
  - fault_store_page(15)
  - fault_load_page(13)
  - fault_s(7)
  - fault_l(5)
- Exception accepted:
  - Latch mcause={0,code}, mepc=epc, mtval=badaddr (mtval=0 for env).
  - Pulse trap_commit; intr=0; go REDIRECT.
- Else interrupt taken if mstatus_mie and any (pending & enable):
  - Priority ext(11) > soft(3) > timer(7).
  - mcause={1,code}; mepc=epc; mtval=0; intr=1.
  - Pulse trap_commit; go REDIRECT.
- Exceptions beat interrupts in the same cycle.
- Else if mret: priv_pc=mepc_r; pulse mret_commit; go REDIRECT.
- Else if wfi: go SLEEP.
- Priority among the three: trap > mret > wfi.
- Trap target: priv_pc={mtvec[XLEN-1:2],2'b00} (see optional feature for vectored mode).

REDIRECT:
- insert_pc=1; priv_pc and intr held stable.
- pipe_clear==1: deassert next cycle, return to IDLE. Latency from accept to insert_pc is 1 cycle.
- No new event accepted in REDIRECT.
- Timeout counter increments each cycle. At RESUME_TIMEOUT, set redirect_err (cleared only by reset) and keep waiting.

SLEEP:
- wfi_sleep=1.
- Wake on any (pending & enable), regardless of mstatus_mie: return to IDLE, wfi_sleep=0 next cycle.
- An enabled-and-global interrupt is then taken from IDLE the following cycle, with epc supplied by the hazard unit.
- Exception inputs are ignored while in SLEEP.

Strobes and widths:
- trap_commit and mret_commit are never high together and never for more than 1 cycle.
- Vectored offset arithmetic is modulo 2^XLEN; no overflow flag.

Optional Feature:
- Macro VECTORED_TRAP_EN.
- Defined:
  - mtvec[1:0]==2'b01 with an interrupt: priv_pc={mtvec[XLEN-1:2],2'b00}+4*code.
  - Exceptions always use the base.
  - mtvec[1:0]>=2 is treated as direct.
- Undefined: mode bits ignored; always direct base.

Test Plan:
- Reset, then illegal_insn=1, epc=0x200, badaddr=0xDEAD, mtvec=0x1000, stall=0:
  - Next cycle trap_commit=1 (1 cycle), mcause=2, mepc=0x200, mtval=0xDEAD.
  - insert_pc=1, priv_pc=0x1000.
  - pipe_clear asserted after 3 cycles: insert_pc drops next cycle.
- breakpoint and fault_l together with ext_int enabled, mstatus_mie=1: mcause=3, intr=0.
- ext_int and timer_int pending and enabled, mstatus_mie=1, ex_mem_stall=1 for 2 cycles:
  - No accept while stalled.
  - After stall drops: mcause=0x8000000B, intr=1.
- mret with mepc_r=0x340: mret_commit pulse, priv_pc=0x340, trap_commit=0.
- wfi with mstatus_mie=0, then timer_int and mie_timer raised:
  - wfi_sleep high until wake, then IDLE.
  - No trap_commit.
- VECTORED_TRAP_EN defined, mtvec=0x1001, soft_int taken: priv_pc=0x100C.
- No pipe_clear for 16 cycles: redirect_err=1, insert_pc still 1.
